// File: rtl/spram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// spram_fifo_pkg
//   Shared constants for the single-port-RAM backed FIFO controller.
//   SPF_DW / SPF_AW      : default data width and RAM address width (64x16 RAM)
//   SPF_DEPTH            : RAM depth (2**SPF_AW)
//   SPF_OB_DEPTH         : entries in the output buffer that sits behind the RAM
//   SPF_OCC_MAX          : largest total occupancy (RAM + output buffer)
//   occ_max()            : occupancy maximum for an arbitrary address width
// -----------------------------------------------------------------------------
package spram_fifo_pkg;

   localparam int SPF_DW       = 16;
   localparam int SPF_AW       = 6;
   localparam int SPF_DEPTH    = 1 << SPF_AW;
   localparam int SPF_OB_DEPTH = 2;
   localparam int SPF_OCC_MAX  = SPF_DEPTH + SPF_OB_DEPTH;

   function automatic int occ_max(input int aw);
      return (1 << aw) + SPF_OB_DEPTH;
   endfunction

endpackage

// File: rtl/spram_fifo_obuf.sv
// -----------------------------------------------------------------------------
// spram_fifo_obuf
//   Two-entry output buffer that holds words already read out of the RAM.
//   Entry 0 is always the head; a pop shifts entry 1 down.  A capture and a pop
//   on the same edge leave the occupancy unchanged and keep word order.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset (contents zeroed)
//     flush        : synchronous clear of the occupancy
//     cap/cap_data : write a RAM read word at the tail
//     pop          : remove the head (ignored when empty)
//     head         : current head word
//     cnt          : occupancy 0..2
// -----------------------------------------------------------------------------
module spram_fifo_obuf
   import spram_fifo_pkg::*;
#(
   parameter int DW = SPF_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          cap,
   input  logic [DW-1:0] cap_data,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic [1:0]    cnt
);

   logic [SPF_OB_DEPTH-1:0][DW-1:0] ent;
   logic                            pop_ok;

   assign pop_ok = pop && (cnt != 2'd0);
   assign head   = ent[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent <= '0;
         cnt <= 2'd0;
      end else if (flush) begin
         cnt <= 2'd0;
      end else begin
         case ({pop_ok, cap})
            2'b11: begin
               // Head leaves, new word joins the tail: occupancy stays put.
               if (cnt == 2'd1) begin
                  ent[0] <= cap_data;
               end else begin
                  ent[0] <= ent[1];
                  ent[1] <= cap_data;
               end
            end
            2'b10: begin
               ent[0] <= ent[1];
               cnt    <= cnt - 2'd1;
            end
            2'b01: begin
               if (cnt == 2'd0) begin
                  ent[0] <= cap_data;
                  cnt    <= 2'd1;
               end else if (cnt == 2'd1) begin
                  ent[1] <= cap_data;
                  cnt    <= 2'd2;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/spram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// spram_fifo_ctrl
//   FIFO controller that stores words in an external single-port RAM and
//   streams them out through a 2-entry output buffer (spram_fifo_obuf).
//   One RAM access per cycle: writes win over reads, except that an empty
//   output path forces a read by dropping in_ready for that cycle.
//   Push-to-out_valid latency into an empty FIFO is 3 cycles.
//   Ports:
//     clk, rst_n                     : clock, asynchronous active-low reset
//     flush                          : synchronous clear of all contents
//     in_valid/in_ready/in_data      : push stream
//     out_valid/out_ready/out_data   : pop stream
//     count                          : RAM words + read in flight + buffered
//     ram_ceb/ram_web/ram_a/ram_d    : RAM controls (active-low enables)
//     ram_q                          : RAM read data, valid the cycle after a read
//     err_ovf/err_udf                : sticky overflow/underflow flags
//   Configuration:
//     SPRAM_FIFO_ERR_CHK_EN          : when defined, enables the sticky error
//                                      flags; otherwise they are tied to 0.
// -----------------------------------------------------------------------------
module spram_fifo_ctrl
   import spram_fifo_pkg::*;
#(
   parameter int DW = SPF_DW,
   parameter int AW = SPF_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [AW:0]   count,
   output logic          ram_ceb,
   output logic          ram_web,
   output logic [AW-1:0] ram_a,
   output logic [DW-1:0] ram_d,
   input  logic [DW-1:0] ram_q,
   output logic          err_ovf,
   output logic          err_udf
);

   localparam int DEPTH = 1 << AW;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;

   ptr_t       wr_ptr;
   ptr_t       rd_ptr;
   cnt_t       ram_cnt;
   logic       inflight;     // read issued last cycle, ram_q valid now
   logic [1:0] ob_cnt;
   logic [1:0] ob_pend;      // buffered words plus the one on its way
   logic       rd_want;
   logic       wr_en;
   logic       rd_grant;
   logic       cap;
   logic       pop;

   // -------------------------------------------------------------------------
   // Arbitration
   // -------------------------------------------------------------------------
   assign ob_pend = ob_cnt + {1'b0, inflight};
   assign rd_want = (ram_cnt != '0) && (ob_pend < 2'd2);

   // When nothing is buffered or on its way, the read must win this cycle or
   // the output would starve behind a continuous push stream.  rst_n gates
   // the handshake so nothing is accepted (and no RAM write issued) in reset.
   assign in_ready = rst_n && (ram_cnt != cnt_t'(DEPTH)) && !flush
                     && !(rd_want && (ob_pend == 2'd0));

   assign wr_en    = in_valid && in_ready;
   assign rd_grant = rd_want && !flush && !wr_en;

   // Read data arriving during a flush belongs to discarded contents.
   assign cap      = inflight && !flush;

   assign out_valid = (ob_cnt != 2'd0) && !flush;
   assign pop       = out_valid && out_ready;

   assign count = ram_cnt + cnt_t'(inflight) + cnt_t'(ob_cnt);

   // -------------------------------------------------------------------------
   // RAM port
   // -------------------------------------------------------------------------
   assign ram_ceb = !(wr_en || rd_grant);
   assign ram_web = !wr_en;
   assign ram_a   = wr_en ? wr_ptr : rd_ptr;
   assign ram_d   = in_data;

   // -------------------------------------------------------------------------
   // Pointers and RAM occupancy (pointers wrap naturally at 2**AW)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
      end else begin
         if (wr_en)    wr_ptr <= wr_ptr + ptr_t'(1);
         if (rd_grant) rd_ptr <= rd_ptr + ptr_t'(1);
         inflight <= rd_grant;
         case ({wr_en, rd_grant})
            2'b10:   ram_cnt <= ram_cnt + cnt_t'(1);
            2'b01:   ram_cnt <= ram_cnt - cnt_t'(1);
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Output buffer
   // -------------------------------------------------------------------------
   spram_fifo_obuf #(
      .DW (DW)
   ) u_obuf (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .cap      (cap),
      .cap_data (ram_q),
      .pop      (pop),
      .head     (out_data),
      .cnt      (ob_cnt)
   );

   // -------------------------------------------------------------------------
   // Sticky error flags
   // -------------------------------------------------------------------------
`ifdef SPRAM_FIFO_ERR_CHK_EN
   localparam int OCC_MAX = occ_max(AW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else if (flush) begin
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else begin
         if (in_valid && !in_ready && (count == cnt_t'(OCC_MAX))) err_ovf <= 1'b1;
         if (out_ready && !out_valid && (count == '0))            err_udf <= 1'b1;
      end
   end
`else
   assign err_ovf = 1'b0;
   assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spram_fifo_ctrl
//   Bench for spram_fifo_ctrl with a behavioural 64x16 single-port RAM.
//   The reference model keeps the FIFO contents as three queues (words in RAM,
//   word being read, words in the output buffer) and derives the expected
//   handshakes, RAM accesses and counts from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_spram_fifo_ctrl;

   localparam int DW    = 16;
   localparam int AW    = 6;
   localparam int DEPTH = 64;
   localparam int OMAX  = 66;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [AW:0]   count;
   logic          ram_ceb, ram_web;
   logic [AW-1:0] ram_a;
   logic [DW-1:0] ram_d, ram_q;
   logic          err_ovf, err_udf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count),
      .ram_ceb(ram_ceb), .ram_web(ram_web), .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q),
      .err_ovf(err_ovf), .err_udf(err_udf)
   );

   // Behavioural single-port RAM: read data valid the cycle after the access.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (!ram_ceb) begin
         if (!ram_web) mem[ram_a] <= ram_d;
         else          ram_q      <= mem[ram_a];
      end
   end

   // ---------------- reference model ----------------
   logic [DW-1:0] mram[$];
   logic [DW-1:0] mfl[$];
   logic [DW-1:0] mob[$];
   int            wptr = 0, rptr = 0;
   bit            mov = 1'b0, mud = 1'b0;
   bit            m_ir, m_ov, m_w, m_g;
   int            m_cnt;
   bit            last_acc, last_pop;
   logic [DW-1:0] last_pdata;
   logic [DW-1:0] got[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int mcount();
      return mram.size() + mfl.size() + mob.size();
   endfunction

   task automatic model_clear();
      mram.delete(); mfl.delete(); mob.delete();
      wptr = 0; rptr = 0; mov = 1'b0; mud = 1'b0;
   endtask

   // Compare DUT combinational outputs against the model (call mid-cycle).
   task automatic model_check();
      int rc, fl, obn;
      bit rw;
      rc  = mram.size();
      fl  = mfl.size();
      obn = mob.size();
      rw    = (rc > 0) && (obn + fl < 2);
      m_ir  = (rc < DEPTH) && !flush && !(rw && (obn + fl == 0));
      m_w   = in_valid && m_ir;
      m_g   = rw && !flush && !m_w;
      m_ov  = (obn > 0) && !flush;
      m_cnt = rc + fl + obn;
      chk("in_ready", in_ready, m_ir);
      chk("out_valid", out_valid, m_ov);
      chk("count", count, m_cnt);
      if (m_ov) chk("out_data", out_data, mob[0]);
      chk("ram_ceb", ram_ceb, !(m_w || m_g));
      chk("ram_web", ram_web, !m_w);
      if (m_w) begin
         chk("wr_addr", ram_a, wptr);
         chk("wr_data", ram_d, in_data);
      end
      if (m_g) chk("rd_addr", ram_a, rptr);
      chk("err_ovf", err_ovf, mov);
      chk("err_udf", err_udf, mud);
   endtask

   // Apply the clock edge to the model (call right after posedge).
   task automatic model_advance();
      logic [DW-1:0] tmp;
      last_acc   = m_w;
      last_pop   = m_ov && out_ready;
      last_pdata = m_ov ? mob[0] : '0;
`ifdef SPRAM_FIFO_ERR_CHK_EN
      if (flush) begin
         mov = 1'b0; mud = 1'b0;
      end else begin
         if (in_valid && !m_ir && m_cnt == OMAX) mov = 1'b1;
         if (out_ready && !m_ov && m_cnt == 0)   mud = 1'b1;
      end
`endif
      if (flush) begin
         mram.delete(); mfl.delete(); mob.delete();
         wptr = 0; rptr = 0;
      end else begin
         if (last_pop) tmp = mob.pop_front();
         if (mfl.size() > 0) begin
            tmp = mfl.pop_front();
            mob.push_back(tmp);
         end
         if (m_w) begin
            mram.push_back(in_data);
            wptr = (wptr + 1) % DEPTH;
         end
         if (m_g) begin
            tmp = mram.pop_front();
            mfl.push_back(tmp);
            rptr = (rptr + 1) % DEPTH;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      last_acc = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (last_acc) break;
      end
      in_valid = 1'b0;
      chk("push_accept", last_acc, 1'b1);
   endtask

   task automatic drain(input int bound);
      for (int k = 0; k < bound; k++) begin
         if (mcount() == 0) break;
         cycle();
         if (last_pop) got.push_back(last_pdata);
      end
      chk("drain_done", mcount(), 0);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit            iv;
      logic [DW-1:0] d;
      bit            ordy;
      bit            fl;
      bit            ir;
      bit            ov;
      logic [DW-1:0] od;
      int            cnt;
      bit            ceb;
      bit            web;
   } vec_t;

   vec_t tv[10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int bad, sent;

      // ---- reset state ----
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_count", count, 0);
      chk("rst_ceb", ram_ceb, 1'b1);
      chk("rst_web", ram_web, 1'b1);
      chk("rst_out_data", out_data, 0);
      chk("rst_err_ovf", err_ovf, 1'b0);
      chk("rst_err_udf", err_udf, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      model_clear();

      // ---- latency / pop / flush table (iv d or fl | ir ov od cnt ceb web) ----
      tv[0] = '{1, 16'h1234, 0, 0, 1, 0, 16'h0000, 0, 0, 0};
      tv[1] = '{0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 1};
      tv[2] = '{0, 16'h0000, 0, 0, 1, 0, 16'h0000, 1, 1, 1};
      tv[3] = '{1, 16'h00AB, 1, 0, 1, 1, 16'h1234, 1, 0, 0};
      tv[4] = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 0, 1};
      tv[5] = '{0, 16'h0000, 1, 0, 1, 0, 16'h0000, 1, 1, 1};
      tv[6] = '{0, 16'h0000, 1, 0, 1, 1, 16'h00AB, 1, 1, 1};
      tv[7] = '{0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 1, 1};
      tv[8] = '{1, 16'h5555, 0, 1, 0, 0, 16'h0000, 0, 1, 1};
      tv[9] = '{0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 1, 1};
      for (int i = 0; i < 10; i++) begin
         in_valid = tv[i].iv; in_data = tv[i].d; out_ready = tv[i].ordy; flush = tv[i].fl;
         @(negedge clk);
         chk($sformatf("tv%0d_in_ready", i), in_ready, tv[i].ir);
         chk($sformatf("tv%0d_out_valid", i), out_valid, tv[i].ov);
         if (tv[i].ov) chk($sformatf("tv%0d_out_data", i), out_data, tv[i].od);
         chk($sformatf("tv%0d_count", i), count, tv[i].cnt);
         chk($sformatf("tv%0d_ceb", i), ram_ceb, tv[i].ceb);
         chk($sformatf("tv%0d_web", i), ram_web, tv[i].web);
         model_check();
         @(posedge clk);
         model_advance();
         #1;
      end
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

      // ---- fill to 66 with out_ready low, then drain in order ----
      for (int i = 0; i < OMAX; i++) push_word(DW'(i));
      cycle(); cycle();
      chk("full_count", count, OMAX);
      chk("full_in_ready", in_ready, 1'b0);
      in_valid = 1'b1; in_data = 16'hDEAD;
      cycle();
      in_valid = 1'b0;
      cycle();
`ifdef SPRAM_FIFO_ERR_CHK_EN
      chk("ovf_set", err_ovf, 1'b1);
      cycle();
      chk("ovf_held", err_ovf, 1'b1);
`else
      chk("ovf_tied", err_ovf, 1'b0);
`endif
      out_ready = 1'b1;
      got.delete();
      drain(400);
      chk("drain_n", got.size(), OMAX);
      bad = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== DW'(i)) bad++;
      chk("drain_order", bad, 0);
      cycle();   // pop attempt while empty
`ifdef SPRAM_FIFO_ERR_CHK_EN
      chk("udf_set", err_udf, 1'b1);
`else
      chk("udf_tied", err_udf, 1'b0);
`endif
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("flush_clr_ovf", err_ovf, 1'b0);
      chk("flush_clr_udf", err_udf, 1'b0);

      // ---- continuous stream of 200 words ----
      out_ready = 1'b1;
      got.delete();
      sent = 0;
      for (int k = 0; k < 3000; k++) begin
         if (got.size() >= 200) break;
         in_valid = (sent < 200);
         in_data  = DW'(1000 + sent);
         cycle();
         if (last_acc) sent++;
         if (last_pop) got.push_back(last_pdata);
      end
      in_valid = 1'b0;
      chk("stream_n", got.size(), 200);
      bad = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== DW'(1000 + i)) bad++;
      chk("stream_order", bad, 0);

      // ---- flush with a read in flight at count 10 ----
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) push_word(DW'(16'h0200 + i));
      for (int k = 0; k < 10; k++) begin
         if (mfl.size() == 1 && mcount() == 10) break;
         cycle();
      end
      chk("preflush_inflight", mfl.size(), 1);
      chk("preflush_count", count, 10);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("postflush_count", count, 0);
      chk("postflush_ov", out_valid, 1'b0);
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         chk("no_stale", out_valid, 1'b0);
      end
      got.delete();
      push_word(16'h7777);
      drain(20);
      chk("after_flush_n", got.size(), 1);
      if (got.size() > 0) chk("after_flush_word", got[0], 16'h7777);

      // ---- randomized traffic ----
      for (int k = 0; k < 900; k++) begin
         in_valid  = ($urandom_range(99) < 60);
         in_data   = DW'($urandom);
         out_ready = ($urandom_range(99) < ((k < 450) ? 20 : 70));
         flush     = ($urandom_range(99) < 2);
         cycle();
      end
      flush = 1'b0;

      // ---- asynchronous reset mid-burst ----
      in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         in_data = DW'($urandom);
         cycle();
      end
      #1 rst_n = 1'b0;
      #1;
      chk("arst_ceb", ram_ceb, 1'b1);
      chk("arst_count", count, 0);
      chk("arst_in_ready", in_ready, 1'b0);
      chk("arst_out_valid", out_valid, 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      model_clear();
      in_valid = 1'b0;
      #1;
      chk("arst_release_ready", in_ready, 1'b1);
      cycle();
      push_word(16'hBEEF);
      got.delete();
      drain(20);
      chk("arst_word", (got.size() > 0) ? got[0] : 16'h0, 16'hBEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
